// File: rtl/fir_coef_loader_if.sv
// Register-block and FIR read-port bundle for the coefficient loader.
// The master side is the register block plus the FIR tap reader.
interface fir_coef_loader_if #(
    parameter int COEF_W = 16
);
    logic [31:0]       coef_data_in;
    logic [31:0]       ctrl_in;
    logic [5:0]        coef_rd_addr;
    logic [COEF_W-1:0] coef_out;

    modport master (
        output coef_data_in,
        output ctrl_in,
        output coef_rd_addr,
        input  coef_out
    );

    modport slave (
        input  coef_data_in,
        input  ctrl_in,
        input  coef_rd_addr,
        output coef_out
    );
endinterface

// File: rtl/fir_coef_loader.sv
// Double-banked FIR coefficient store, loaded one tap pair per command
// through toggle-encoded controls and swapped on a frame boundary.
module fir_coef_loader #(
    parameter int N_TAPS = 32,
    parameter int COEF_W = 16
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    fir_coef_loader_if.slave bus,
    input  logic             sync_in,
    output logic             busy,
    output logic             swap_pending,
    output logic             active_bank,
    output logic [1:0]       err_flags,
    output logic [15:0]      load_count
);
    localparam int IW = $clog2(N_TAPS);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR_EVEN = 2'd1;
    localparam logic [1:0] WR_ODD  = 2'd2;

    logic [1:0]        state;
    logic [2:0]        ctrl_q;
    logic [2:0]        ev;
    logic              wr_ev;
    logic              cm_ev;
    logic              clr_ev;
    logic [5:0]        k_in;
    logic              k_ok;
    logic              wr_ok;
    logic              q_take;
    logic              drop;
    logic              swap;
    logic              q_valid;
    logic [31:0]       q_data;
    logic [IW-2:0]     q_k;
    logic [31:0]       cap_data;
    logic [IW-2:0]     cap_k;
    logic [1:0]        err_nx;
    logic              we;
    logic [IW-1:0]     wr_addr;
    logic [15:0]       wr_half;
    logic [IW-1:0]     rd_idx;
    logic              rd_ok;
    logic [COEF_W-1:0] coef_q;
    logic              unused_ctrl;

    logic [COEF_W-1:0] bank [2][N_TAPS];

    // A command is any change of a toggle bit since the previous cycle.
    assign ev     = bus.ctrl_in[31:29] ^ ctrl_q;
    assign wr_ev  = ev[2];
    assign cm_ev  = ev[1];
    assign clr_ev = ev[0];

    assign k_in  = bus.ctrl_in[5:0];
    assign k_ok  = {1'b0, k_in} < 7'(N_TAPS / 2);
    assign wr_ok = wr_ev & k_ok;

    assign busy = (state != IDLE);

    // In IDLE the queue slot is being drained, so a new write refills it.
    assign q_take = wr_ok & (busy ? ~q_valid : q_valid);
    assign drop   = wr_ok & busy & q_valid;
    assign swap   = sync_in & swap_pending & ~busy & ~q_valid;

    assign unused_ctrl = ^bus.ctrl_in[28:6];

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state      <= IDLE;
            ctrl_q     <= 3'b000;
            q_valid    <= 1'b0;
            q_data     <= '0;
            q_k        <= '0;
            cap_data   <= '0;
            cap_k      <= '0;
            load_count <= '0;
        end else begin
            ctrl_q <= bus.ctrl_in[31:29];
            unique case (state)
                IDLE: begin
                    if (q_valid) begin
                        cap_data <= q_data;
                        cap_k    <= q_k;
                        state    <= WR_EVEN;
                    end else if (wr_ok) begin
                        cap_data <= bus.coef_data_in;
                        cap_k    <= k_in[IW-2:0];
                        state    <= WR_EVEN;
                    end
                end
                WR_EVEN: state <= WR_ODD;
                WR_ODD: begin
                    load_count <= load_count + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (q_take) begin
                q_valid <= 1'b1;
                q_data  <= bus.coef_data_in;
                q_k     <= k_in[IW-2:0];
            end else if (!busy) begin
                q_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        err_nx = clr_ev ? 2'b00 : err_flags;
        if (wr_ev && !k_ok) err_nx[0] = 1'b1;
        if (drop) err_nx[1] = 1'b1;
    end

    assign we      = (state == WR_EVEN) || (state == WR_ODD);
    assign wr_addr = {cap_k, state == WR_ODD};
    assign wr_half = (state == WR_ODD) ? cap_data[15:0]
                                       : cap_data[31:16];

    always_ff @(posedge user_clk) begin
        if (we) bank[~active_bank][wr_addr] <= COEF_W'(wr_half);
    end

    assign rd_idx = bus.coef_rd_addr[IW-1:0];
    assign rd_ok  = {1'b0, bus.coef_rd_addr} < 7'(N_TAPS);

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
            err_flags    <= 2'b00;
            coef_q       <= '0;
        end else begin
            err_flags <= err_nx;
            if (swap) begin
                active_bank  <= ~active_bank;
                swap_pending <= 1'b0;
            end else if (cm_ev) begin
                swap_pending <= 1'b1;
            end
            coef_q <= rd_ok ? bank[active_bank][rd_idx] : '0;
        end
    end

    assign bus.coef_out = coef_q;
endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 The block SHALL have parameter N_TAPS, default 32, giving the FIR tap count; it SHALL be even and no greater than 64.
REQ-002 The block SHALL have parameter COEF_W, default 16, giving the coefficient width in bits.
REQ-003 Port user_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port user_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port coef_data_in, input, 32 bits: from the register block. [31:16] is the even tap (b2k), [15:0] is the odd tap (b2k+1).
REQ-006 Port ctrl_in, input, 32 bits: from the register block. [5:0] is the pair index k, [31] is the write toggle, [30] is the commit toggle, [29] is the error-clear toggle.
REQ-007 Port sync_in, input, 1 bit: FIR frame-boundary pulse.
REQ-008 Port coef_rd_addr, input, 6 bits: tap address read by the FIR.
REQ-009 Port coef_out, output, COEF_W bits: the active-bank coefficient at coef_rd_addr.
REQ-010 Port busy, output, 1 bit: the FSM is not in IDLE.
REQ-011 Port swap_pending, output, 1 bit: a commit is waiting for sync_in.
REQ-012 Port active_bank, output, 1 bit: the bank currently read by the FIR.
REQ-013 Port err_flags, output, 2 bits: [0] is index out of range, [1] is command dropped.
REQ-014 Port load_count, output, 16 bits: the number of completed pair writes.

Function
REQ-015 Storage SHALL be two banks of N_TAPS x COEF_W: the shadow bank (written) and the active bank (read).
REQ-016 Toggle detection: the block SHALL register ctrl_in[31:29] each cycle; any bit differing from its registered value is a command event in that cycle.
REQ-017 The FSM SHALL have states IDLE, WR_EVEN and WR_ODD.
REQ-018 IDLE + write event + k < N_TAPS/2 -> the block SHALL capture coef_data_in and k, then go to WR_EVEN.
REQ-019 WR_EVEN SHALL write the captured [31:16] to shadow address 2k, then go to WR_ODD.
REQ-020 WR_ODD SHALL write the captured [15:0] to shadow address 2k+1, increment load_count (wrapping 0xFFFF->0), then go to IDLE.
REQ-021 Write event + k >= N_TAPS/2 -> the block SHALL write nothing, set err_flags[0] sticky, and leave the FSM in IDLE.
REQ-022 Write event while busy: if no write is queued, the block SHALL latch coef_data_in and k into a one-deep queue and execute it on the first cycle back in IDLE.
REQ-023 Write event while busy with a write already queued: the block SHALL drop the event and set err_flags[1] sticky.
REQ-024 Commit event SHALL set swap_pending in the next cycle.
REQ-025 Commit event while swap_pending is already set SHALL be a no-op.
REQ-026 sync_in=1 with swap_pending=1, FSM in IDLE and no write queued: on that edge the block SHALL toggle active_bank and clear swap_pending.
REQ-027 sync_in with the FSM busy or a write queued SHALL be ignored; the swap waits for a later sync_in.
REQ-028 Commit event and sync_in in the same cycle: the swap SHALL NOT occur on that edge; it SHALL occur on the next qualifying sync_in.
REQ-029 An error-clear event SHALL clear err_flags in the next cycle.
REQ-030 Error-clear and a new error in the same cycle: set SHALL win.
REQ-031 coef_out SHALL equal active_bank[coef_rd_addr], registered with 1-cycle latency.
REQ-032 coef_rd_addr >= N_TAPS SHALL give coef_out = 0.
REQ-033 After a swap, the new shadow bank holds stale contents; software SHALL rewrite every pair before the next commit (not checked in hardware).
REQ-034 Write latency: write event at edge n -> even tap written at n+1, odd tap at n+2, busy high for cycles n+1..n+2.

Reset
REQ-035 On user_rst_n=0, the block SHALL immediately force: FSM to IDLE, queue empty, busy=0, swap_pending=0, active_bank=0, err_flags=0, load_count=0, coef_out=0, toggle history registers=0.
REQ-036 Bank RAM contents SHALL NOT be reset.
REQ-037 Reset during WR_EVEN or WR_ODD SHALL abort the write; a partial pair write is permitted.
REQ-038 After reset release, the first toggle bit that reads 1 SHALL count as an event.

Verification
REQ-039 Scenario: coef_data_in=0x1234ABCD, k=3, flip bit31, commit, pulse sync_in -> active_bank=1; rd_addr 6 -> coef_out 0x1234 one cycle later; rd_addr 7 -> 0xABCD; load_count=1.
REQ-040 Scenario: k=16 (N_TAPS=32) write event -> no write, err_flags=01, busy stays 0; flip bit29 -> err_flags=00.
REQ-041 Scenario: three write events in 3 consecutive cycles -> first executes, second queued and written afterwards, third dropped; err_flags[1]=1, load_count=2.
REQ-042 Scenario: commit and sync_in in the same cycle -> active_bank unchanged; next sync_in -> active_bank toggles, swap_pending=0.
REQ-043 Scenario: sync_in while in WR_ODD with swap_pending=1 -> no swap; sync_in 5 cycles later -> swap.
REQ-044 Scenario: assert user_rst_n=0 mid-WR_EVEN -> all outputs return to reset values asynchronously; load_count=0, active_bank=0.
